tpu_mac_sequencer: RTL and testbench
====================================

# tpu_mac_sequencer

Control sequencer for the TPU systolic-array datapath: on a host `start` it clears the DIM×DIM accumulator rows, then runs the array for the skewed-operand window of one DIM×DIM matrix multiply, and finally pulses `done`. It also arbitrates access to the array's C-row write port and A/B operand-buffer write port between the host MMIO path and itself, blocking host writes while a multiply is in flight. It sits between the MMIO decode logic and the systolic array / A-B operand buffers inside `tpuv1`.

## Interface
- `DIM`, default 8: array dimension; must be ≥2.
- `STEPW`, default `$clog2(3*DIM-2)`: width of the skew-step index.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request one multiply; honoured only in IDLE.
- `host_c_wr` in 1: host C-row write request.
- `host_c_row` in `$clog2(DIM)`: host C-row index.
- `host_ab_wr` in 1: host A/B operand-buffer write request.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at multiply completion.
- `cal_en` out 1: systolic-array compute enable.
- `ab_shift` out 1: advance A/B operand buffers one skew step.
- `step` out STEPW: current skew step, 0..3*DIM-3 during COMPUTE, else 0.
- `c_wr_en` out 1: C-row write enable to array.
- `c_row` out `$clog2(DIM)`: C row addressed.
- `c_clr` out 1: select zero as C write data (clear).
- `ab_wr_en` out 1: gated A/B buffer write enable.
- `host_blocked` out 1: host write request dropped because busy.

## Operation
- FSM states: IDLE, CLEAR, COMPUTE, DONE. One counter `cnt` shared by CLEAR and COMPUTE.
- IDLE: `start`=1 → CLEAR, `cnt`←0. Otherwise stay.
- CLEAR: `c_wr_en`=1, `c_clr`=1, `c_row`=`cnt`. When `cnt`=DIM-1 → COMPUTE, `cnt`←0; else `cnt`++.
- COMPUTE: `cal_en`=1, `ab_shift`=1, `step`=`cnt`. When `cnt`=3*DIM-3 → DONE; else `cnt`++.
- DONE: `done`=1 for exactly one cycle → IDLE unconditionally.
- FSM outputs (`cal_en`, `ab_shift`, `step`, `c_clr`, `done`, `busy`) are decoded from registered state/counter (Moore); no combinational path from `start`.
- Host arbitration (combinational): in IDLE, `c_wr_en`=`host_c_wr`, `c_row`=`host_c_row`, `c_clr`=0, `ab_wr_en`=`host_ab_wr`. While `busy`, host writes are suppressed: `ab_wr_en`=0, C port owned by FSM, `host_blocked`=`busy & (host_c_wr | host_ab_wr)`.
- `start` in CLEAR/COMPUTE/DONE is ignored (not queued). `start` held high through DONE starts a new multiply on the first IDLE cycle.
- Counter width is the larger of `$clog2(DIM)` and STEPW; no wrap occurs within a state because terminal values are compared exactly.

## Timing
- Reset (async assert, sync release): state=IDLE, `cnt`=0; `busy`, `done`, `cal_en`, `ab_shift`, `c_clr`, `step`=0; `c_wr_en`/`c_row`/`ab_wr_en` follow host inputs, `host_blocked`=0.
- `start` sampled at edge k → CLEAR during cycles k+1..k+DIM → COMPUTE k+DIM+1..k+4DIM-2 (3*DIM-2 cycles) → DONE at k+4DIM-1 → IDLE at k+4DIM.
- Latency start→`done` = 4*DIM-1 cycles (31 for DIM=8); back-to-back throughput one multiply per 4*DIM cycles.
- `busy` rises the cycle after `start` is sampled and falls the cycle after DONE.
- Reset mid-operation: immediate return to IDLE; partial C contents are not restored; no `done` pulse.

## Structure
- Shared package `tpu_pkg`: state enum `tpu_seq_state_t` {IDLE, CLEAR, COMPUTE, DONE}; helper constants `CLR_CYCLES`=DIM and `CMP_CYCLES`=3*DIM-2 as localparams or package functions of DIM.
- Single module, no sub-module: one FSM register, one counter, combinational output/arbitration decode.

## Test plan
- DIM=8, reset then `start` pulse at cycle 0 → `c_wr_en`&`c_clr` high cycles 1–8 with `c_row` 0..7; `cal_en`/`ab_shift` high cycles 9–30 with `step` 0..21; `done` high only cycle 31; `busy` high cycles 1–31.
- `host_c_wr`=1, `host_ab_wr`=1 held through a multiply → pass-through in IDLE; during busy `ab_wr_en`=0, `c_clr`=1 in CLEAR, `host_blocked`=1 every busy cycle.
- `start` pulsed again at cycles 5 and 20 of a run → ignored; exactly one `done` at cycle 31.
- `start` held high continuously → `done` at cycles 31, 63, 95; `busy` low only cycles 32, 64.
- Assert `rst` at cycle 15 (COMPUTE) → all registered outputs 0 within the same cycle, no `done`; new `start` afterwards gives full 31-cycle sequence.
- DIM=2 build → CLEAR 2 cycles, COMPUTE 4 cycles with `step` 0..3, `done` at start+7.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU MAC sequencer: FSM state encoding and
// phase-length helpers expressed as functions of the array dimension.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } tpu_seq_state_t;

  // Accumulator rows cleared before a multiply.
  function automatic int clr_cycles(input int dim);
    return dim;
  endfunction

  // Skewed-operand window of one DIM x DIM multiply.
  function automatic int cmp_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/tpu_mac_sequencer.sv
// Systolic-array control sequencer: clears C rows, runs the skewed compute
// window, pulses done, and arbitrates array/buffer write ports against the host.
module tpu_mac_sequencer
  import tpu_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int STEPW = $clog2(3*DIM-2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   host_c_wr,
  input  logic [$clog2(DIM)-1:0] host_c_row,
  input  logic                   host_ab_wr,
  output logic                   busy,
  output logic                   done,
  output logic                   cal_en,
  output logic                   ab_shift,
  output logic [STEPW-1:0]       step,
  output logic                   c_wr_en,
  output logic [$clog2(DIM)-1:0] c_row,
  output logic                   c_clr,
  output logic                   ab_wr_en,
  output logic                   host_blocked
);

  localparam int ROWW = $clog2(DIM);
  localparam int CNTW = (ROWW > STEPW) ? ROWW : STEPW;
  localparam logic [CNTW-1:0] CLR_LAST = CNTW'(clr_cycles(DIM) - 1);
  localparam logic [CNTW-1:0] CMP_LAST = CNTW'(cmp_cycles(DIM) - 1);

  tpu_seq_state_t  state;
  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          if (cnt == CLR_LAST) begin
            state <= COMPUTE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        COMPUTE: begin
          if (cnt == CMP_LAST) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Moore decode of FSM outputs plus host arbitration; host inputs reach the
  // ports only in IDLE, otherwise the sequencer owns the C write port.
  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    cal_en       = (state == COMPUTE);
    ab_shift     = (state == COMPUTE);
    step         = (state == COMPUTE) ? cnt[STEPW-1:0] : '0;
    c_clr        = (state == CLEAR);
    c_wr_en      = 1'b0;
    c_row        = '0;
    ab_wr_en     = 1'b0;
    host_blocked = 1'b0;
    case (state)
      IDLE: begin
        c_wr_en  = host_c_wr;
        c_row    = host_c_row;
        ab_wr_en = host_ab_wr;
      end
      CLEAR: begin
        c_wr_en      = 1'b1;
        c_row        = cnt[ROWW-1:0];
        host_blocked = host_c_wr | host_ab_wr;
      end
      default: begin
        host_blocked = host_c_wr | host_ab_wr;
      end
    endcase
  end

endmodule

// File: tb/tb_tpu_mac_sequencer.sv
// Scoreboard bench for tpu_mac_sequencer: DIM=8 and DIM=2 instances share
// stimulus; a timeline model predicts outputs, a monitor compares each cycle.
module tb_tpu_mac_sequencer;

  localparam int D8 = 8;
  localparam int D2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic host_c_wr = 1'b0;
  logic host_ab_wr = 1'b0;
  logic [2:0] host_c_row = '0;

  always #5 clk = ~clk;

  logic       busy8, done8, cal_en8, ab_shift8, c_wr_en8, c_clr8, ab_wr_en8, hb8;
  logic [4:0] step8;
  logic [2:0] c_row8;
  logic       busy2, done2, cal_en2, ab_shift2, c_wr_en2, c_clr2, ab_wr_en2, hb2;
  logic [1:0] step2;
  logic [0:0] c_row2;

  tpu_mac_sequencer #(.DIM(D8)) dut8 (
    .clk(clk), .rst(rst), .start(start),
    .host_c_wr(host_c_wr), .host_c_row(host_c_row), .host_ab_wr(host_ab_wr),
    .busy(busy8), .done(done8), .cal_en(cal_en8), .ab_shift(ab_shift8),
    .step(step8), .c_wr_en(c_wr_en8), .c_row(c_row8), .c_clr(c_clr8),
    .ab_wr_en(ab_wr_en8), .host_blocked(hb8)
  );

  tpu_mac_sequencer #(.DIM(D2)) dut2 (
    .clk(clk), .rst(rst), .start(start),
    .host_c_wr(host_c_wr), .host_c_row(host_c_row[0:0]), .host_ab_wr(host_ab_wr),
    .busy(busy2), .done(done2), .cal_en(cal_en2), .ab_shift(ab_shift2),
    .step(step2), .c_wr_en(c_wr_en2), .c_row(c_row2), .c_clr(c_clr2),
    .ab_wr_en(ab_wr_en2), .host_blocked(hb2)
  );

  int checks = 0;
  int passed = 0;
  logic [23:0] q8[$];
  logic [23:0] q2[$];

  // Phase p: 0 when idle, otherwise cycles elapsed since start was accepted.
  int p8 = 0;
  int p2 = 0;

  function automatic int next_phase(input int p, input int dim, input logic st);
    if (p == 0) return st ? 1 : 0;
    if (p == 4*dim - 1) return 0;
    return p + 1;
  endfunction

  function automatic logic [23:0] pack(input logic b, input logic d, input logic ce,
                                       input logic sh, input logic clr, input logic cw,
                                       input logic abw, input logic hb,
                                       input logic [7:0] st, input logic [7:0] row);
    logic [7:0] mrow;
    mrow = cw ? row : 8'd0;
    return {b, d, ce, sh, clr, cw, abw, hb, st, mrow};
  endfunction

  function automatic logic [23:0] model_out(input int p, input int dim, input logic hc,
                                            input logic [7:0] hr, input logic hab);
    logic b, d, clr, comp, cw;
    logic [7:0] st, row;
    b    = (p != 0);
    d    = (p == 4*dim - 1);
    clr  = (p >= 1) && (p <= dim);
    comp = (p >= dim + 1) && (p <= 4*dim - 2);
    st   = comp ? 8'(p - dim - 1) : 8'd0;
    cw   = b ? clr : hc;
    row  = b ? (clr ? 8'(p - 1) : 8'd0) : hr;
    return pack(b, d, comp, comp, clr, cw, b ? 1'b0 : hab, b & (hc | hab), st, row);
  endfunction

  always @(negedge clk) begin
    logic [23:0] e, a;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      a = pack(busy8, done8, cal_en8, ab_shift8, c_clr8, c_wr_en8, ab_wr_en8, hb8,
               8'(step8), 8'(c_row8));
      checks++;
      if (a === e) passed++;
      else $display("FAIL dim8_outputs t=%0t actual=%h required=%h (busy,done,cal,shift,clr,cwr,abwr,hblk,step,row)",
                    $time, a, e);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      a = pack(busy2, done2, cal_en2, ab_shift2, c_clr2, c_wr_en2, ab_wr_en2, hb2,
               8'(step2), 8'(c_row2));
      checks++;
      if (a === e) passed++;
      else $display("FAIL dim2_outputs t=%0t actual=%h required=%h (busy,done,cal,shift,clr,cwr,abwr,hblk,step,row)",
                    $time, a, e);
    end
  end

  // One clock: retire the edge in the model, apply new inputs, queue expectations.
  task automatic cycle(input logic st, input logic hc, input logic [2:0] hr,
                       input logic hab, input logic r);
    @(posedge clk);
    #1;
    p8 = rst ? 0 : next_phase(p8, D8, start);
    p2 = rst ? 0 : next_phase(p2, D2, start);
    start      = st;
    host_c_wr  = hc;
    host_c_row = hr;
    host_ab_wr = hab;
    rst        = r;
    if (r) begin
      p8 = 0;
      p2 = 0;
    end
    q8.push_back(model_out(p8, D8, hc, 8'(hr), hab));
    q2.push_back(model_out(p2, D2, hc, 8'(hr[0]), hab));
  endtask

  initial begin
    repeat (3) cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Single start pulse, host writes held high throughout.
    cycle(1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
    repeat (36) cycle(1'b0, 1'b1, 3'd5, 1'b1, 1'b0);

    // Extra start pulses inside a run are ignored.
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i < 36; i++)
      cycle((i == 5) || (i == 20), 1'b0, 3'(i), 1'b0, 1'b0);

    // Start held continuously: back-to-back multiplies.
    repeat (100) cycle(1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (35) cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Reset in the middle of COMPUTE, then a clean run.
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (14) cycle(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (35) cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Randomized traffic with occasional starts and a rare reset.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) == 0), 1'($urandom), 3'($urandom), 1'($urandom),
            ($urandom_range(0, 149) == 0));
    repeat (35) cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (q8.size() == 0 && q2.size() == 0) passed++;
    else $display("FAIL scoreboard_drain actual=%0d/%0d pending required=0/0", q8.size(), q2.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
